// File: rtl/px_rect_fill_if.sv
// VRAM write port shared between the rectangle-fill engine and the VRAM arbiter.
interface px_rect_fill_if #(
   parameter int ADDR_W = 17
) ();
   logic [ADDR_W-1:0] vram_addr;
   logic [7:0]        vram_d;
   logic              vram_we;
   logic              vram_grant;

   modport master (
      output vram_addr,
      output vram_d,
      output vram_we,
      input  vram_grant
   );

   modport slave (
      input  vram_addr,
      input  vram_d,
      input  vram_we,
      output vram_grant
   );
endinterface

// File: rtl/px_rect_fill.sv
// Rectangle-fill engine: writes one RGB332 colour over a clipped rectangle of
// the pixel plane, one pixel per granted cycle.
//
// state  | meaning
// IDLE   | waiting for start; abort ignored
// SETUP  | clip rectangle, compute base address (1 cycle)
// FILL   | vram_we high, advance on each granted write
// FINISH | done pulse, busy low (1 cycle)
module px_rect_fill #(
   parameter int H_RES  = 320,
   parameter int V_RES  = 240,
   parameter int ADDR_W = 17
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       start,
   input  logic       abort,
   input  logic [8:0] x0,
   input  logic [7:0] y0,
   input  logic [8:0] width,
   input  logic [7:0] height,
   input  logic [7:0] color,
   output logic       busy,
   output logic       done,
   px_rect_fill_if.master vram
);

   typedef enum logic [1:0] {IDLE, SETUP, FILL, FINISH} state_t;

   localparam logic [9:0] H_RES_W = 10'(H_RES);
   localparam logic [8:0] V_RES_W = 9'(V_RES);

   state_t state, state_nxt;

   logic [8:0]        x0_q;
   logic [7:0]        y0_q;
   logic [8:0]        width_q;
   logic [7:0]        height_q;
   logic [7:0]        color_q;
   logic [9:0]        cw_q;
   logic [8:0]        ch_q;
   logic [9:0]        col_q;
   logic [8:0]        row_q;
   logic [ADDR_W-1:0] addr_q;

   logic [9:0]        rem_x;
   logic [8:0]        rem_y;
   logic [9:0]        cw_c;
   logic [8:0]        ch_c;
   logic [ADDR_W-1:0] base_c;
   logic              empty_c;
   logic              col_last;
   logic              row_last;

   // Clip the latched rectangle against the plane and form its base address.
   always_comb begin
      rem_x = H_RES_W - {1'b0, x0_q};
      rem_y = V_RES_W - {1'b0, y0_q};
      cw_c  = 10'd0;
      ch_c  = 9'd0;
      if ({1'b0, x0_q} < H_RES_W)
         cw_c = ({1'b0, width_q} < rem_x) ? {1'b0, width_q} : rem_x;
      if ({1'b0, y0_q} < V_RES_W)
         ch_c = ({1'b0, height_q} < rem_y) ? {1'b0, height_q} : rem_y;
      base_c   = ADDR_W'(y0_q) * ADDR_W'(H_RES) + ADDR_W'(x0_q);
      empty_c  = (cw_c == 10'd0) || (ch_c == 9'd0);
      col_last = (col_q == cw_q - 10'd1);
      row_last = (row_q == ch_q - 9'd1);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!nreset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      vram.vram_we = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = SETUP;
         end
         SETUP: begin
            busy = 1'b1;
            if (abort || empty_c)
               state_nxt = FINISH;
            else
               state_nxt = FILL;
         end
         FILL: begin
            busy         = 1'b1;
            vram.vram_we = 1'b1;
            if (abort || (vram.vram_grant && col_last && row_last))
               state_nxt = FINISH;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Parameter latch, clipped sizes, pixel counters and write address.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         x0_q     <= '0;
         y0_q     <= '0;
         width_q  <= '0;
         height_q <= '0;
         color_q  <= '0;
         cw_q     <= '0;
         ch_q     <= '0;
         col_q    <= '0;
         row_q    <= '0;
         addr_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x0_q     <= x0;
                  y0_q     <= y0;
                  width_q  <= width;
                  height_q <= height;
                  color_q  <= color;
               end
            end
            SETUP: begin
               cw_q <= cw_c;
               ch_q <= ch_c;
               if (!empty_c) begin
                  col_q  <= '0;
                  row_q  <= '0;
                  addr_q <= base_c;
               end
            end
            FILL: begin
               if (vram.vram_grant) begin
                  if (!col_last) begin
                     col_q  <= col_q + 10'd1;
                     addr_q <= addr_q + ADDR_W'(1);
                  end else if (!row_last) begin
                     col_q  <= '0;
                     row_q  <= row_q + 9'd1;
                     // jump from the right edge to the left edge of the next line
                     addr_q <= addr_q + ADDR_W'(H_RES) - ADDR_W'(cw_q) + ADDR_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign vram.vram_addr = addr_q;
   assign vram.vram_d    = color_q;

endmodule

// File: tb/tb_px_rect_fill.sv
// Directed bench for px_rect_fill: logs committed writes and done pulses,
// checks addresses, data, counts and cycle timing against hand-computed values.
module tb_px_rect_fill;

   logic       clk = 1'b0;
   logic       nreset;
   logic       start;
   logic       abort;
   logic [8:0] x0;
   logic [7:0] y0;
   logic [8:0] width;
   logic [7:0] height;
   logic [7:0] color;
   logic       busy;
   logic       done;

   px_rect_fill_if #(.ADDR_W(17)) vif ();

   px_rect_fill #(.H_RES(320), .V_RES(240), .ADDR_W(17)) dut (
      .clk    (clk),
      .nreset (nreset),
      .start  (start),
      .abort  (abort),
      .x0     (x0),
      .y0     (y0),
      .width  (width),
      .height (height),
      .color  (color),
      .busy   (busy),
      .done   (done),
      .vram   (vif.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int waddr[$];
   int wdata[$];
   int wcyc[$];
   int done_cnt = 0;
   int done_cyc = -1;
   int busy_cnt = 0;
   int tests = 0;
   int fails = 0;

   // cycle index: the clock period following posedge k is labelled k
   always @(posedge clk) cyc <= cyc + 1;

   // commit / done / busy monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (vif.vram_we && vif.vram_grant) begin
         waddr.push_back(int'(vif.vram_addr));
         wdata.push_back(int'(vif.vram_d));
         wcyc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cnt++;
   end

   task automatic chk(input string tag, input longint obs, input longint expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int at_addr(input int idx);
      return (idx < waddr.size()) ? waddr[idx] : -1;
   endfunction

   function automatic int at_data(input int idx);
      return (idx < wdata.size()) ? wdata[idx] : -1;
   endfunction

   function automatic int at_cyc(input int idx);
      return (idx < wcyc.size()) ? wcyc[idx] : -1;
   endfunction

   // called #1 after a posedge; returns #1 after the next posedge
   task automatic start_fill(input int x, input int y, input int w, input int h,
                             input int c, input logic with_abort, output int n);
      x0     = 9'(x);
      y0     = 8'(y);
      width  = 9'(w);
      height = 8'(h);
      color  = 8'(c);
      start  = 1'b1;
      abort  = with_abort;
      n      = cyc;
      @(posedge clk); #1;
      start  = 1'b0;
      abort  = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done_cnt != d0) break;
         @(posedge clk); #1;
      end
      chk("done_seen", done_cnt - d0, 1);
   endtask

   initial begin
      int n, w0, d0, b0;
      int exp_a[6];
      exp_a = '{1610, 1611, 1612, 1930, 1931, 1932};

      nreset = 1'b0; start = 1'b0; abort = 1'b0;
      x0 = '0; y0 = '0; width = '0; height = '0; color = '0;
      vif.vram_grant = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", vif.vram_we, 0);
      chk("rst_addr", vif.vram_addr, 0);
      chk("rst_d", vif.vram_d, 0);
      nreset = 1'b1;
      @(posedge clk); #1;

      // basic fill
      w0 = waddr.size(); d0 = done_cnt; b0 = busy_cnt;
      start_fill(10, 5, 3, 2, 'hE0, 1'b0, n);
      wait_done(d0, 40);
      chk("basic_count", waddr.size() - w0, 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("basic_addr%0d", i), at_addr(w0 + i), exp_a[i]);
         chk($sformatf("basic_data%0d", i), at_data(w0 + i), 'hE0);
         chk($sformatf("basic_cyc%0d", i), at_cyc(w0 + i) - n, 2 + i);
      end
      chk("basic_done_lat", done_cyc - n, 8);
      chk("basic_busy_len", busy_cnt - b0, 7);
      @(posedge clk); #1;

      // clipping at the bottom-right corner
      w0 = waddr.size(); d0 = done_cnt;
      start_fill(318, 239, 5, 4, 'h1C, 1'b0, n);
      wait_done(d0, 40);
      chk("clip_count", waddr.size() - w0, 2);
      chk("clip_addr0", at_addr(w0), 76798);
      chk("clip_addr1", at_addr(w0 + 1), 76799);
      chk("clip_done_lat", done_cyc - n, 4);
      @(posedge clk); #1;

      // fully off-plane rectangle
      w0 = waddr.size(); d0 = done_cnt;
      start_fill(320, 0, 5, 5, 'h03, 1'b0, n);
      wait_done(d0, 40);
      chk("empty_count", waddr.size() - w0, 0);
      chk("empty_done_lat", done_cyc - n, 2);
      @(posedge clk); #1;

      // grant stall on the second pixel
      w0 = waddr.size(); d0 = done_cnt;
      start_fill(10, 5, 3, 2, 'hE0, 1'b0, n);
      @(posedge clk); #1;
      @(posedge clk); #1;
      vif.vram_grant = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("stall_addr%0d", i), vif.vram_addr, 1611);
         chk($sformatf("stall_we%0d", i), vif.vram_we, 1);
         @(posedge clk); #1;
      end
      vif.vram_grant = 1'b1;
      wait_done(d0, 40);
      chk("stall_count", waddr.size() - w0, 6);
      chk("stall_addr_last", at_addr(w0 + 5), 1932);
      chk("stall_done_lat", done_cyc - n, 11);
      @(posedge clk); #1;

      // abort on the 11th write cycle of a 100x100 fill
      w0 = waddr.size(); d0 = done_cnt;
      start_fill(5, 3, 100, 100, 'h55, 1'b0, n);
      repeat (11) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_count", waddr.size() - w0, 11);
      chk("abort_last_addr", at_addr(w0 + 10), 975);
      chk("abort_we", vif.vram_we, 0);
      chk("abort_done", done, 1);
      chk("abort_busy", busy, 0);
      @(posedge clk); #1;
      chk("abort_done_once", done_cnt - d0, 1);

      // abort alone in IDLE is ignored
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_done", done, 0);

      // start and abort together in IDLE: start wins
      w0 = waddr.size(); d0 = done_cnt;
      start_fill(2, 1, 1, 1, 'h7F, 1'b1, n);
      wait_done(d0, 40);
      chk("startabort_count", waddr.size() - w0, 1);
      chk("startabort_addr", at_addr(w0), 322);
      chk("startabort_data", at_data(w0), 'h7F);
      @(posedge clk); #1;

      // second start while busy is ignored
      w0 = waddr.size(); d0 = done_cnt;
      start_fill(10, 5, 3, 2, 'hE0, 1'b0, n);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      x0 = 9'd0; y0 = 8'd0; width = 9'd50; height = 8'd50; color = 8'h1C;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(d0, 40);
      repeat (6) begin @(posedge clk); #1; end
      chk("busystart_count", waddr.size() - w0, 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("busystart_addr%0d", i), at_addr(w0 + i), exp_a[i]);
         chk($sformatf("busystart_data%0d", i), at_data(w0 + i), 'hE0);
      end
      chk("busystart_done_lat", done_cyc - n, 8);
      chk("busystart_single_done", done_cnt - d0, 1);

      // reset in the middle of a fill
      w0 = waddr.size(); d0 = done_cnt;
      start_fill(10, 5, 3, 2, 'hE0, 1'b0, n);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      nreset = 1'b0;
      @(posedge clk); #1;
      nreset = 1'b1;
      chk("rstmid_we", vif.vram_we, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_done", done, 0);
      chk("rstmid_addr", vif.vram_addr, 0);
      repeat (10) begin @(posedge clk); #1; end
      chk("rstmid_count", waddr.size() - w0, 3);
      chk("rstmid_no_done", done_cnt - d0, 0);

      w0 = waddr.size(); d0 = done_cnt;
      start_fill(0, 0, 1, 1, 'hAA, 1'b0, n);
      wait_done(d0, 40);
      chk("after_rst_count", waddr.size() - w0, 1);
      chk("after_rst_addr", at_addr(w0), 0);
      chk("after_rst_data", at_data(w0), 'hAA);
      chk("after_rst_done_lat", done_cyc - n, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
